// File: rtl/sha_pkg.sv
// Types and default constants shared by the SHA-256 host memory block and its
// engine-side bench.
package sha_pkg;

    typedef enum logic [2:0] {
        LOAD      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        DRAIN     = 3'd4
    } host_state_t;

    localparam int          HASH_WORDS   = 8;
    localparam logic [15:0] DEF_MSG_BASE = 16'h0000;
    localparam logic [15:0] DEF_OUT_BASE = 16'h0040;

endpackage

// File: rtl/sha_word_ram.sv
// DEPTH x 32 single-port word memory with a registered read port and an
// out-of-range flag for addresses at or above DEPTH.
module sha_word_ram #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        oor
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    assign oor = ({16'd0, addr} >= 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (we && !oor)
            mem[addr[AW-1:0]] <= wdata;
    end

    // Read-first: a same-cycle write is seen on the following access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rdata <= 32'd0;
        else
            rdata <= oor ? 32'd0 : mem[addr[AW-1:0]];
    end

endmodule

// File: rtl/sha_mem_host.sv
// Host-side memory responder and job sequencer for the SHA-256 engine.
// Optional watchdog on the WAIT states: define SHA_MEM_HOST_TIMEOUT_EN.
module sha_mem_host
    import sha_pkg::*;
#(
    parameter int          NUM_OF_WORDS   = 20,
    parameter int          DEPTH          = 256,
    parameter logic [15:0] MSG_BASE       = DEF_MSG_BASE,
    parameter logic [15:0] OUT_BASE       = DEF_OUT_BASE,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        start,
    input  logic        done,
    output logic [15:0] message_addr,
    output logic [15:0] output_addr,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        err,
    output logic [2:0]  state_dbg
);
    // Handshake rule on both streams: a word moves on a rising clk edge where
    // valid and ready are both high; valid never waits on ready, and a
    // presented word (data, last) holds until it moves.
    localparam logic [7:0] LAST_MSG  = 8'(NUM_OF_WORDS - 1);
    localparam logic [7:0] LAST_HASH = 8'(HASH_WORDS - 1);

    host_state_t state;
    logic [7:0]  cnt;
    logic        pend;
    logic        ram_we, ram_oor;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        eng_active, load_hs, out_hs, timeout;
    logic [7:0]  drain_idx;

    assign message_addr  = MSG_BASE;
    assign output_addr   = OUT_BASE;
    assign mem_read_data = ram_rdata;
    assign state_dbg     = state;

    assign eng_active = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign load_hs    = (state == LOAD) && in_valid && in_ready;
    assign out_hs     = out_valid && out_ready;
    // Prefetch the next hash word during the handshake cycle to keep gaps to one cycle.
    assign drain_idx  = out_hs ? cnt + 8'd1 : cnt;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = mem_addr;
        ram_wdata = mem_write_data;
        case (state)
            LOAD: begin
                ram_we    = load_hs;
                ram_addr  = MSG_BASE + {8'd0, cnt};
                ram_wdata = in_data;
            end
            WAIT_BUSY, WAIT_DONE: ram_we = mem_we;
            DRAIN:    ram_addr = OUT_BASE + {8'd0, drain_idx};
            default:  ;
        endcase
    end

    sha_word_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .addr    (ram_addr),
        .wdata   (ram_wdata),
        .rdata   (ram_rdata),
        .oor     (ram_oor)
    );

`ifdef SHA_MEM_HOST_TIMEOUT_EN
    logic [15:0] wd_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wd_cnt <= 16'd0;
        else if (state == START)
            wd_cnt <= 16'd0;
        else if (eng_active)
            wd_cnt <= wd_cnt + 16'd1;
    end

    assign timeout = eng_active && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = |TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LOAD;
            cnt       <= 8'd0;
            pend      <= 1'b0;
            start     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            start <= 1'b0;
            if ((eng_active && ram_oor) || (!eng_active && mem_we) || timeout)
                err <= 1'b1;
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (load_hs) begin
                        if (cnt == LAST_MSG) begin
                            cnt      <= 8'd0;
                            in_ready <= 1'b0;
                            start    <= 1'b1;
                            state    <= START;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                START: state <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (timeout) begin
                        pend  <= 1'b0;
                        state <= DRAIN;
                    end else if (!done) begin
                        state <= WAIT_DONE;
                    end
                end
                // Only reached after done was seen low, so done high here is a real completion.
                WAIT_DONE: begin
                    if (done || timeout) begin
                        pend  <= 1'b0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pend) begin
                        pend      <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= ram_rdata;
                        out_last  <= (cnt == LAST_HASH);
                    end else if (out_hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (cnt == LAST_HASH) begin
                            cnt   <= 8'd0;
                            state <= LOAD;
                        end else begin
                            cnt  <= cnt + 8'd1;
                            pend <= 1'b1;
                        end
                    end else if (!out_valid) begin
                        pend <= 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_mem_host.sv
// Directed bench for sha_mem_host with a bench-driven stub engine on the memory port.
module tb_sha_mem_host;
  import sha_pkg::*;

  localparam logic [15:0] MSG_BASE = 16'h0000;
  localparam logic [15:0] OUT_BASE = 16'h0040;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        start;
  logic        done = 1'b1;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = 16'd0;
  logic [31:0] mem_write_data = 32'd0;
  logic [31:0] mem_read_data;
  logic        err;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  sha_mem_host #(
    .NUM_OF_WORDS(20), .DEPTH(256), .MSG_BASE(MSG_BASE), .OUT_BASE(OUT_BASE), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .start(start), .done(done), .message_addr(message_addr), .output_addr(output_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    total++; if (state_dbg !== 3'(LOAD)) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, LOAD); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0 || out_last !== 1'b0 || start !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_flags: valid=%b last=%b start=%b err=%b want all 0", out_valid, out_last, start, err); end
    total++; if (out_data !== 32'd0 || mem_read_data !== 32'd0) begin
      bad++; $display("FAIL reset_data: out_data=%h rd=%h want 0", out_data, mem_read_data); end
    total++; if (message_addr !== MSG_BASE || output_addr !== OUT_BASE) begin
      bad++; $display("FAIL base_addrs: msg=%h out=%h want %h %h", message_addr, output_addr, MSG_BASE, OUT_BASE); end
    reset_n = 1'b1;
    tick();
  endtask

  // Loads 20 words base+n with in_valid held high; checks accept count and start pulse.
  task automatic test_load(input logic [31:0] base);
    int n = 0;
    logic acc;
    in_valid = 1'b1;
    in_data  = base;
    for (int c = 0; c < 100 && n < 20; c++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        n++;
        in_data = base + 32'(n);
      end
    end
    in_valid = 1'b0;
    total++; if (n != 20) begin bad++; $display("FAIL load_accepts: got %0d want 20", n); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL load_in_ready_drop: got %b want 0", in_ready); end
    total++; if (start !== 1'b1 || state_dbg !== 3'(START)) begin
      bad++; $display("FAIL start_pulse_hi: start=%b state=%0d want 1 %0d", start, state_dbg, START); end
    tick();
    total++; if (start !== 1'b0 || state_dbg !== 3'(WAIT_BUSY)) begin
      bad++; $display("FAIL start_pulse_lo: start=%b state=%0d want 0 %0d", start, state_dbg, WAIT_BUSY); end
  endtask

  // Engine still idle (done=1) must not look like completion; then the engine goes busy.
  task automatic test_wait_busy();
    done = 1'b1;
    repeat (3) tick();
    total++; if (state_dbg !== 3'(WAIT_BUSY)) begin bad++; $display("FAIL busy_hold: got %0d want %0d", state_dbg, WAIT_BUSY); end
    done = 1'b0;
    tick();
    total++; if (state_dbg !== 3'(WAIT_DONE)) begin bad++; $display("FAIL wait_done: got %0d want %0d", state_dbg, WAIT_DONE); end
  endtask

  task automatic test_read_latency();
    mem_addr = MSG_BASE + 16'd3;
    tick();
    total++; if (mem_read_data !== 32'h1000_0003) begin bad++; $display("FAIL rd_lat_t1: got %h want 10000003", mem_read_data); end
    mem_addr = MSG_BASE + 16'd4;
    #1;
    total++; if (mem_read_data !== 32'h1000_0003) begin bad++; $display("FAIL rd_lat_hold: got %h want 10000003", mem_read_data); end
    tick();
    total++; if (mem_read_data !== 32'h1000_0004) begin bad++; $display("FAIL rd_lat_next: got %h want 10000004", mem_read_data); end
    mem_addr = MSG_BASE + 16'd5;
    tick();
    total++; if (mem_read_data !== 32'h1000_0005) begin bad++; $display("FAIL msg_word5: got %h want 10000005", mem_read_data); end
    mem_addr = MSG_BASE + 16'd19;
    tick();
    total++; if (mem_read_data !== 32'h1000_0013) begin bad++; $display("FAIL msg_word19: got %h want 10000013", mem_read_data); end
  endtask

  // Stub engine writes the digest, then raises done.
  task automatic engine_write_hash();
    for (int k = 0; k < 8; k++) begin
      mem_we = 1'b1;
      mem_addr = OUT_BASE + 16'(k);
      mem_write_data = 32'hA5A5_0000 + 32'(k);
      tick();
    end
    mem_we = 1'b0;
    mem_addr = OUT_BASE + 16'd2;
    tick();
    total++; if (mem_read_data !== 32'hA5A5_0002) begin bad++; $display("FAIL eng_write_rb: got %h want a5a50002", mem_read_data); end
    mem_addr = 16'd0;
    done = 1'b1;
    tick();
    total++; if (state_dbg !== 3'(DRAIN)) begin bad++; $display("FAIL enter_drain: got %0d want %0d", state_dbg, DRAIN); end
  endtask

  // Drain 8 words; word 2 is held off for 5 cycles.
  task automatic test_drain_backpressure();
    int got = 0;
    int stall = 0;
    int gap = 0;
    logic [31:0] exp;
    for (int k = 0; k < 8; k++) exp_q.push_back(32'hA5A5_0000 + 32'(k));
    for (int c = 0; c < 200 && got < 8; c++) begin
      if (out_valid) begin
        if (got == 2 && stall < 5) begin
          out_ready = 1'b0;
          stall++;
          total++; if (out_data !== 32'hA5A5_0002 || out_last !== 1'b0) begin
            bad++; $display("FAIL stall_hold: data=%h last=%b want a5a50002 0", out_data, out_last); end
        end else begin
          out_ready = 1'b1;
          exp = exp_q.pop_front();
          total++; if (out_data !== exp) begin bad++; $display("FAIL drain_word%0d: got %h want %h", got, out_data, exp); end
          total++; if (out_last !== (got == 7)) begin bad++; $display("FAIL drain_last%0d: got %b want %b", got, out_last, got == 7); end
          if (got > 0) begin
            total++; if (gap > 1) begin bad++; $display("FAIL drain_gap%0d: got %0d idle want <=1", got, gap); end
          end
          gap = 0;
          got++;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        if (got > 0) gap++;
      end
      tick();
    end
    out_ready = 1'b0;
    total++; if (got != 8 || exp_q.size() != 0) begin bad++; $display("FAIL drain_count: got %0d want 8", got); end
    total++; if (stall != 5) begin bad++; $display("FAIL stall_cycles: got %0d want 5", stall); end
    total++; if (out_valid !== 1'b0 || state_dbg !== 3'(LOAD)) begin
      bad++; $display("FAIL drain_end: valid=%b state=%0d want 0 %0d", out_valid, state_dbg, LOAD); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL job_err: got %b want 0", err); end
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reload_ready: got %b want 1", in_ready); end
  endtask

  // Out-of-range engine read/write during WAIT_DONE; 0x140 would alias OUT_BASE if not dropped.
  task automatic test_out_of_range();
    mem_addr = 16'h0100;
    tick();
    total++; if (mem_read_data !== 32'd0) begin bad++; $display("FAIL oor_read: got %h want 0", mem_read_data); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_err: got %b want 1", err); end
    mem_we = 1'b1;
    mem_addr = 16'h0140;
    mem_write_data = 32'h1234_5678;
    tick();
    mem_we = 1'b0;
    mem_addr = OUT_BASE;
    tick();
    total++; if (mem_read_data !== 32'hA5A5_0000) begin bad++; $display("FAIL oor_write_dropped: got %h want a5a50000", mem_read_data); end
    mem_addr = MSG_BASE + 16'd7;
    tick();
    total++; if (mem_read_data !== 32'h2000_0007) begin bad++; $display("FAIL reload_word7: got %h want 20000007", mem_read_data); end
    mem_addr = 16'd0;
    done = 1'b1;
    reset_n = 1'b0;
    #1;
    total++; if (err !== 1'b0 || state_dbg !== 3'(LOAD)) begin
      bad++; $display("FAIL reset_clears_err: err=%b state=%0d want 0 %0d", err, state_dbg, LOAD); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_err_load();
    mem_we = 1'b1;
    mem_addr = OUT_BASE + 16'd1;
    mem_write_data = 32'hDEAD_BEEF;
    tick();
    mem_we = 1'b0;
    mem_addr = 16'd0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL load_we_err: got %b want 1", err); end
    test_load(32'h3000_0000);
    test_wait_busy();
    mem_addr = OUT_BASE + 16'd1;
    tick();
    total++; if (mem_read_data !== 32'hA5A5_0001) begin bad++; $display("FAIL load_we_ignored: got %h want a5a50001", mem_read_data); end
  endtask

  task automatic test_reset_mid_drain();
    int c = 0;
    mem_addr = 16'd0;
    done = 1'b1;
    out_ready = 1'b0;
    while (!out_valid && c < 20) begin
      tick();
      c++;
    end
    total++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0000) begin
      bad++; $display("FAIL drain2_first: valid=%b data=%h want 1 a5a50000", out_valid, out_data); end
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL mid_reset_async: valid=%b err=%b want 0 0", out_valid, err); end
    #1;
    reset_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0 || state_dbg !== 3'(LOAD)) begin
      bad++; $display("FAIL mid_reset_after: ready=%b valid=%b err=%b state=%0d want 1 0 0 %0d",
                      in_ready, out_valid, err, state_dbg, LOAD); end
  endtask

  initial begin
    test_reset();
    test_load(32'h1000_0000);
    test_wait_busy();
    test_read_latency();
    engine_write_hash();
    test_drain_backpressure();
    test_load(32'h2000_0000);
    test_wait_busy();
    test_out_of_range();
    test_err_load();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
